// File: rtl/fp_mult_result_fifo.sv
// fp_mult_result_fifo: tracks fp_mult issues through its latency and buffers results in a credit-controlled FIFO.
// Optional sticky exception flags are enabled by defining FP_MULT_RESULT_STICKY_FLAGS_EN.
module fp_mult_result_fifo #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         issue_ready,
    input  logic [31:0]                  z_in,
    input  logic [7:0]                   status_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_z,
    output logic [7:0]                   out_status,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [5:0]                   sticky_flags,
    input  logic                         flags_clr,
    output logic                         drop_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int UW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic [IW-1:0]      inflight;
    logic               issue, push, pop;
    logic [39:0]        mem_q [DEPTH];

    // Count operations still travelling through the multiplier.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(vld_q[i]);
    end

    // Credit reserves a slot for every in-flight result, so a push never meets a full FIFO.
    assign issue_ready = (UW'(cnt_q) + UW'(inflight)) < UW'(DEPTH);
    assign issue       = in_valid & issue_ready;
    assign push        = vld_q[LATENCY-1];
    assign out_valid   = cnt_q != '0;
    assign pop         = out_valid & out_ready;
    assign count       = cnt_q;
    assign drop_err    = drop_q;
    assign {out_z, out_status} = mem_q[rd_q];

    // Next state for the tracking pipe, pointers, occupancy and drop flag.
    always_comb begin
        vld_d  = LATENCY'({vld_q, issue});
        wr_d   = push ? wr_q + PW'(1) : wr_q;
        rd_d   = pop ? rd_q + PW'(1) : rd_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        drop_d = drop_q | (in_valid & ~issue_ready);
    end

    // Control state; reset discards everything buffered or in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Result storage is not reset; out_valid alone qualifies the head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {z_in, status_in};
    end

`ifdef FP_MULT_RESULT_STICKY_FLAGS_EN
    logic [5:0] flags_q, flags_d;
    logic       unused_bits;
    assign unused_bits  = ^status_in[7:6];
    assign sticky_flags = flags_q;

    // A clear wipes history but keeps the flags of a result pushed in the same cycle.
    always_comb begin
        flags_d = (flags_clr ? 6'b0 : flags_q) | (push ? status_in[5:0] : 6'b0);
    end

    // Sticky flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= '0;
        else      flags_q <= flags_d;
    end
`else
    logic unused_bits;
    assign unused_bits  = ^{flags_clr, status_in[7:6]};
    assign sticky_flags = 6'b0;
`endif
endmodule

// File: tb/tb_fp_mult_result_fifo.sv
// tb_fp_mult_result_fifo: directed checks of latency, credit, drops, wrap, flags and reset.
module tb_fp_mult_result_fifo;
    logic        clk = 1'b0;
    logic        rst, in_valid, issue_ready, out_valid, out_ready, flags_clr, drop_err;
    logic [31:0] z_in, out_z, iz;
    logic [7:0]  status_in, out_status, ist;
    logic [2:0]  count;
    logic [5:0]  sticky_flags;
    int          total = 0;
    int          bad = 0;
    int          acc;

`ifdef FP_MULT_RESULT_STICKY_FLAGS_EN
    localparam logic [5:0] EXP_F = 6'h24;
`else
    localparam logic [5:0] EXP_F = 6'h00;
`endif

    fp_mult_result_fifo #(.DEPTH(4), .LATENCY(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .issue_ready(issue_ready),
        .z_in(z_in), .status_in(status_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_status(out_status), .count(count), .sticky_flags(sticky_flags),
        .flags_clr(flags_clr), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // The multiplier stand-in presents the result of last cycle's issue.
    task automatic tick();
        @(posedge clk);
        #1;
        z_in = iz;
        status_in = ist;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
        iz = '0; ist = '0; z_in = '0; status_in = '0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_drop", drop_err, 0);
        chk("rst_flags", sticky_flags, 0);
        tick(); tick();
        rst = 1'b1;
        // single op 1.5 x 2.0 = 3.0
        out_ready = 1'b1;
        in_valid = 1'b1; iz = 32'h4040_0000; ist = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("t1_valid_t1", out_valid, 0);
        chk("t1_count_t1", count, 0);
        tick();
        chk("t1_valid_t2", out_valid, 1);
        chk("t1_z", out_z, 32'h4040_0000);
        chk("t1_status", out_status, 8'h00);
        chk("t1_count_t2", count, 1);
        tick();
        chk("t1_count_t3", count, 0);
        // backpressure with continuous issue attempts
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; iz = 32'hA0 + i;
            if (issue_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_accepted", acc, 4);
        chk("t2_count_full", count, 4);
        chk("t2_ready_low", issue_ready, 0);
        chk("t2_drop", drop_err, 1);
        chk("t2_head_held", out_z, 32'hA0);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("t3_drop_survives_clr", drop_err, 1);
        chk("t3_count_unchanged", count, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_valid", out_valid, 1);
            chk("t2_drain_z", out_z, 32'hA0 + i);
            chk("t2_drain_count", count, 4 - i);
            tick();
        end
        chk("t2_empty_valid", out_valid, 0);
        chk("t2_empty_count", count, 0);
        // sustained push/pop from empty with pointer wrap
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10); iz = 32'hB000_0000 + i;
            if (i < 10) chk("t4_ready", issue_ready, 1);
            if (i >= 2) begin
                chk("t4_valid", out_valid, 1);
                chk("t4_z", out_z, 32'hB000_0000 + i - 2);
                chk("t4_count", count, 1);
            end
            tick();
        end
        chk("t4_end_count", count, 0);
        // sticky flags: overflow result then a clean result with clear
        in_valid = 1'b1; iz = 32'h7F80_0000; ist = 8'h24;
        tick();
        in_valid = 1'b1; iz = 32'h3F80_0000; ist = 8'h00;
        chk("t5_flags_before", sticky_flags, 0);
        tick();
        in_valid = 1'b0; flags_clr = 1'b1;
        chk("t5_flags_acc", sticky_flags, EXP_F);
        chk("t5_z_big", out_z, 32'h7F80_0000);
        chk("t5_status_big", out_status, 8'h24);
        tick();
        flags_clr = 1'b0;
        chk("t5_flags_clr_push", sticky_flags, 0);
        chk("t5_z_one", out_z, 32'h3F80_0000);
        chk("t5_status_one", out_status, 8'h00);
        tick();
        chk("t5_count_end", count, 0);
        // reset mid-stream with three buffered and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; iz = 32'hE0 + i;
            tick();
        end
        in_valid = 1'b0;
        chk("t6_count_pre", count, 3);
        chk("t6_ready_pre", issue_ready, 0);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_ready", issue_ready, 1);
        chk("t6_rst_drop", drop_err, 0);
        tick();
        rst = 1'b1; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_stale_valid", out_valid, 0);
        chk("t6_no_stale_count", count, 0);
        in_valid = 1'b1; iz = 32'hF00D_0001;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_new_valid", out_valid, 1);
        chk("t6_new_z", out_z, 32'hF00D_0001);
        tick();
        chk("t6_new_count", count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
